// File: rtl/div_seq_disp.sv
// Sequential restoring divider, one quotient bit per clock, with a scanned
// 8-digit common-anode hex readout (quotient on digits 7..4, remainder on 3..0).
module div_seq_disp #(
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic [7:0]       c,
   output logic [7:0]       en
);

   localparam int ND = WIDTH / 4;
   localparam int CW = $clog2(WIDTH);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    POP_MASK  = 4'((1 << ND) - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [SW-1:0]    scan_q, scan_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       c_q, c_d;
   logic [7:0]       en_q, en_d;

   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   diff_s;
   logic             qbit_s;
   logic [WIDTH-1:0] rem_nxt_s;
   logic [WIDTH-1:0] field_s;
   logic [3:0]       nib_s;

   function automatic logic [7:0] seg_font(input logic [3:0] nib);
      case (nib)
         4'h0: seg_font = 8'hC0;
         4'h1: seg_font = 8'hF9;
         4'h2: seg_font = 8'hA4;
         4'h3: seg_font = 8'hB0;
         4'h4: seg_font = 8'h99;
         4'h5: seg_font = 8'h92;
         4'h6: seg_font = 8'h82;
         4'h7: seg_font = 8'hF8;
         4'h8: seg_font = 8'h80;
         4'h9: seg_font = 8'h90;
         4'hA: seg_font = 8'h88;
         4'hB: seg_font = 8'h83;
         4'hC: seg_font = 8'hC6;
         4'hD: seg_font = 8'hA1;
         4'hE: seg_font = 8'h86;
         4'hF: seg_font = 8'h8E;
         default: seg_font = 8'hFF;
      endcase
   endfunction

   // State register and all datapath/display flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dvd_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         q_q     <= {WIDTH{1'b0}};
         r_q     <= {WIDTH{1'b0}};
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         scan_q  <= {SW{1'b0}};
         idx_q   <= 3'd0;
         c_q     <= 8'hC0;
         en_q    <= 8'hFE;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         en_q    <= en_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && (b != {WIDTH{1'b0}})) state_d = S_CALC;
            else if (start)                    state_d = S_DONE;
            else                               state_d = S_IDLE;
         end
         S_CALC: begin
            if (cnt_q == CNT_LAST) state_d = S_DONE;
            else                   state_d = S_CALC;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode, registered from the next state so busy/done never glitch
   always_comb begin
      busy_d = (state_d == S_CALC);
      done_d = (state_d == S_DONE);
   end

   // One restoring step: trial never exceeds 2*divisor-1, so one subtract suffices
   always_comb begin
      trial_s   = {rem_q, dvd_q[WIDTH-1]};
      diff_s    = trial_s - {1'b0, dvs_q};
      qbit_s    = (trial_s >= {1'b0, dvs_q});
      if (qbit_s) rem_nxt_s = diff_s[WIDTH-1:0];
      else        rem_nxt_s = trial_s[WIDTH-1:0];
   end

   // Operand capture, iteration and result latch
   always_comb begin
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      q_d   = q_q;
      r_d   = r_q;
      dz_d  = dz_q;
      case (state_q)
         S_IDLE: begin
            if (start && (b != {WIDTH{1'b0}})) begin
               dvd_d = a;
               dvs_d = b;
               rem_d = {WIDTH{1'b0}};
               cnt_d = {CW{1'b0}};
            end else if (start) begin
               dz_d = 1'b1;
               q_d  = {WIDTH{1'b1}};
               r_d  = a;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[WIDTH-2:0], qbit_s};
            rem_d = rem_nxt_s;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               q_d  = {dvd_q[WIDTH-2:0], qbit_s};
               r_d  = rem_nxt_s;
               dz_d = 1'b0;
            end else begin
               q_d = q_q;
            end
         end
         S_DONE:  cnt_d = cnt_q;
         default: cnt_d = cnt_q;
      endcase
   end

   // Free-running digit scan
   always_comb begin
      if (scan_q == SCAN_LAST) begin
         scan_d = {SW{1'b0}};
         idx_d  = idx_q + 3'd1;
      end else begin
         scan_d = scan_q + SW'(1);
         idx_d  = idx_q;
      end
   end

   // Segment/enable decode from next-cycle values so the readout tracks index and results
   always_comb begin
      if (idx_d[2]) field_s = q_d;
      else          field_s = r_d;
      nib_s = 4'(field_s >> {idx_d[1:0], 2'b00});
      if (!POP_MASK[idx_d[1:0]]) begin
         en_d = 8'hFF;
         c_d  = 8'hFF;
      end else begin
         en_d = ~(8'd1 << idx_d);
         if (idx_d[2] && dz_d) c_d = seg_font(4'hE);
         else                  c_d = seg_font(nib_s);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
   assign q    = q_q;
   assign r    = r_q;
   assign c    = c_q;
   assign en   = en_q;

endmodule

// File: doc/div_seq_disp.md
# div_seq_disp

Parametrised sequential restoring divider with a scanned seven-segment readout. It accepts unsigned `WIDTH`-bit dividend and divisor operands under a start/busy/done handshake and produces one quotient bit per clock. It holds the quotient, remainder and a divide-by-zero flag until the next start. It drives an 8-digit common-anode tube, showing the quotient on digits 7..4 and the remainder on digits 3..0 in hex. It sits between the switch/keypad input logic and the board display, and is the successor of the fixed 3-bit combinational divider.

## Interface
- `WIDTH`, 8, operand/quotient/remainder width; legal values 4, 8, 12, 16. `ND = WIDTH/4` hex digits per field.
- `SCAN_DIV`, 50000, clock cycles each display digit is held; must be ≥ 2.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `a`  in  `WIDTH`  dividend, captured on an accepted start.
- `b`  in  `WIDTH`  divisor, captured on an accepted start.
- `busy`  out  1  high while an iterative division is in progress.
- `done`  out  1  one-cycle pulse when `q`, `r` and `dz` become valid.
- `dz`  out  1  divide-by-zero flag for the last operation.
- `q`  out  `WIDTH`  quotient, held until the next done.
- `r`  out  `WIDTH`  remainder, held until the next done.
- `c`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1.
- `en`  out  8  digit enables, active-low, one-hot-low.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with `start`=1 and `b`≠0: load dividend shift register ← `a`, divisor ← `b`, partial remainder ← 0, iteration counter ← 0; go to CALC.
- IDLE with `start`=1 and `b`=0: go directly to DONE with `dz`←1, `q`←all ones, `r`←`a`.
- CALC, one iteration per cycle:
  - Form a trial value of `WIDTH`+1 bits: {rem, next dividend MSB}.
  - If trial ≥ divisor, rem ← trial − divisor and shift in quotient bit 1; otherwise rem ← trial and shift in 0.
  - No overflow is possible; rem always stays < divisor.
  - After `WIDTH` iterations, go to DONE.
- On the edge entering DONE from CALC: `q`, `r` update, and `dz`←0.
- DONE lasts exactly one cycle with `done`=1, then returns to IDLE.
- `start` in CALC or DONE is ignored and not queued. Operands are used only at capture; later changes to `a`/`b` have no effect.
- Display:
  - A free-running scan counter runs 0..`SCAN_DIV`−1. On wrap, the digit index 0..7 increments and wraps 7→0.
  - Index k drives `en` = ~(1<<k).
  - Index k<`ND` shows nibble k of `r`.
  - Index 4+k with k<`ND` shows nibble k of `q`, or 'E' on every quotient digit when `dz`=1.
  - Unpopulated indices drive `en`=8'hFF and `c`=8'hFF.
- Hex font (`c`): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- `c`/`en` are registered, and are updated on the cycle the index changes or when `q`/`r`/`dz` change.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `dz`=0, `q`=0, `r`=0, scan counter 0, index 0, `en`=8'hFE, `c`=8'hC0.
- Start accepted at edge E0. Then `busy`=1 for cycles E0+1 .. E0+`WIDTH`. `done`=1, `busy`=0, and results are valid in cycle E0+`WIDTH`+1. The next start can be accepted at edge E0+`WIDTH`+2.
- Divide by zero: `done`=1 in cycle E0+1; `busy` never asserts.
- `done` and `busy` are never high together.
- Reset asserted mid-CALC aborts the operation: no `done`, and results clear to 0.
- During CALC the display continues to show the previous `q`/`r`.

## Test plan
All scenarios use `WIDTH`=8, `SCAN_DIV`=4.
- 200/7 → `q`=0x1C, `r`=0x04, `dz`=0, `done` exactly 9 cycles after the start edge. During scan: index 5 `c`=F9, index 4 `c`=C6, index 1 `c`=C0, index 0 `c`=99.
- `a`=0x55, `b`=0 → `done` 1 cycle after start, `dz`=1, `q`=0xFF, `r`=0x55. Indices 4,5 show `c`=86; indices 1,0 show 92,92.
- 3/9 → `q`=0, `r`=3. A second start pulse with 255/1 at cycle 3 of CALC is ignored: results stay 0/3, and only one `done` pulse occurs.
- 255/1 → `q`=0xFF, `r`=0. Then 255/255 → `q`=1, `r`=0. Then 128/16 → `q`=8, `r`=0.
- Scan check: `en` sequence FE, FD, FF, FF, EF, DF, FF, FF, each held 4 cycles, then repeats. Unpopulated slots show `c`=FF.
- `rst_n` pulsed low at cycle 4 of CALC → asynchronously `busy`=0, `q`=0, `r`=0, `en`=FE, `c`=C0, with no `done`. A new start after release divides correctly: 100/3 → `q`=33, `r`=1.
